// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and helpers for the IF->ID instruction fetch queue.
// FQ_BYPASS_EN (see inst_fetch_queue.sv) is not referenced here.
package inst_fetch_queue_pkg;

    localparam int FQ_DEPTH_DEF   = 4;
    localparam int FQ_PC_WD_DEF   = 32;
    localparam int FQ_INST_WD_DEF = 32;

    typedef enum logic [1:0] {
        FQ_EMPTY   = 2'd0,
        FQ_PARTIAL = 2'd1,
        FQ_FULL    = 2'd2
    } fq_occ_e;

    function automatic int fq_bus_wd(input int pc_wd, input int inst_wd);
        return pc_wd + inst_wd;
    endfunction

    // Classify occupancy so the handshake logic reads in terms of empty/full.
    function automatic fq_occ_e fq_occ(input int count, input int depth);
        if (count == 0) begin
            return FQ_EMPTY;
        end else if (count >= depth) begin
            return FQ_FULL;
        end else begin
            return FQ_PARTIAL;
        end
    endfunction

endpackage

// File: rtl/fq_ram.sv
// DEPTH x WD register array: one synchronous write port, asynchronous read,
// cleared on reset so the head bus reads zero out of reset.
module fq_ram #(
    parameter int DEPTH = 4,
    parameter int WD    = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [WD-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [WD-1:0] rdata
);

    logic [WD-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Decoupling queue between IF and ID holding up to DEPTH {pc,inst} entries.
// Optional zero-latency empty-queue bypass is enabled by defining FQ_BYPASS_EN.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter  int DEPTH   = FQ_DEPTH_DEF,
    parameter  int PC_WD   = FQ_PC_WD_DEF,
    parameter  int INST_WD = FQ_INST_WD_DEF,
    localparam int CNT_WD  = $clog2(DEPTH + 1),
    localparam int BUS_WD  = fq_bus_wd(PC_WD, INST_WD)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              fs_to_fq_valid,
    output logic              fq_allowin,
    input  logic [BUS_WD-1:0] fs_to_fq_bus,
    output logic              fq_to_ds_valid,
    input  logic              ds_allowin,
    output logic [BUS_WD-1:0] fq_to_ds_bus,
    output logic [CNT_WD-1:0] fq_count
);

    localparam int PTR_WD = $clog2(DEPTH);

    // Handshake: a transfer happens on an edge where the producer's valid and the
    // consumer's allowin are both high; valid never depends on the consumer's
    // allowin, and fq_allowin depends only on registered occupancy.

    logic [PTR_WD-1:0] wr_ptr;
    logic [PTR_WD-1:0] rd_ptr;
    logic [CNT_WD-1:0] count;
    logic [CNT_WD-1:0] count_nxt;
    fq_occ_e           occ;

    logic              push;
    logic              pop;
    logic              bypass;
    logic              wr_en;
    logic              rd_en;
    logic [BUS_WD-1:0] ram_rdata;

    assign occ        = fq_occ(int'(count), DEPTH);
    assign fq_allowin = (occ != FQ_FULL);
    assign fq_count   = count;

`ifdef FQ_BYPASS_EN
    // Empty queue forwards the incoming entry straight to ID.
    assign bypass         = (occ == FQ_EMPTY) && fs_to_fq_valid && !flush;
    assign fq_to_ds_valid = ((occ != FQ_EMPTY) || bypass) && !flush;
    assign fq_to_ds_bus   = (occ == FQ_EMPTY) ? fs_to_fq_bus : ram_rdata;
`else
    assign bypass         = 1'b0;
    assign fq_to_ds_valid = (occ != FQ_EMPTY) && !flush;
    assign fq_to_ds_bus   = ram_rdata;
`endif

    assign push  = fs_to_fq_valid && fq_allowin && !flush;
    assign pop   = fq_to_ds_valid && ds_allowin;
    // An entry consumed through the bypass is never stored.
    assign wr_en = push && !(bypass && ds_allowin);
    assign rd_en = pop && (occ != FQ_EMPTY);

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
        end
    end

    fq_ram #(
        .DEPTH (DEPTH),
        .WD    (BUS_WD),
        .AW    (PTR_WD)
    ) u_fq_ram (
        .clk    (clk),
        .resetn (resetn),
        .we     (wr_en),
        .waddr  (wr_ptr),
        .wdata  (fs_to_fq_bus),
        .raddr  (rd_ptr),
        .rdata  (ram_rdata)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue (DEPTH=4, 32-bit pc/inst); honours FQ_BYPASS_EN.
module tb_inst_fetch_queue;

    localparam int DEPTH   = 4;
    localparam int PC_WD   = 32;
    localparam int INST_WD = 32;
    localparam int BUS_WD  = PC_WD + INST_WD;
    localparam int CNT_WD  = $clog2(DEPTH + 1);

    logic              clk;
    logic              resetn;
    logic              flush;
    logic              fs_to_fq_valid;
    logic              fq_allowin;
    logic [BUS_WD-1:0] fs_to_fq_bus;
    logic              fq_to_ds_valid;
    logic              ds_allowin;
    logic [BUS_WD-1:0] fq_to_ds_bus;
    logic [CNT_WD-1:0] fq_count;

    logic [BUS_WD-1:0] exp_q[$];
    int                m_count;
    int                n_checks;
    int                n_fail;
    logic              popped;
    logic [PC_WD-1:0]  popped_pc;

    inst_fetch_queue #(
        .DEPTH   (DEPTH),
        .PC_WD   (PC_WD),
        .INST_WD (INST_WD)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .fs_to_fq_valid (fs_to_fq_valid),
        .fq_allowin     (fq_allowin),
        .fs_to_fq_bus   (fs_to_fq_bus),
        .fq_to_ds_valid (fq_to_ds_valid),
        .ds_allowin     (ds_allowin),
        .fq_to_ds_bus   (fq_to_ds_bus),
        .fq_count       (fq_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver + scoreboard: drive one cycle of inputs, check outputs mid-cycle
    // against the model, then advance the model across the posedge.
    task automatic step(input logic fv, input logic [PC_WD-1:0] pc,
                        input logic da, input logic fl);
        logic [BUS_WD-1:0] in_bus;
        logic              byp;
        logic              exp_valid;
        logic              push;
        logic              pop;
        in_bus         = {pc, INST_WD'($urandom())};
        fs_to_fq_valid = fv;
        fs_to_fq_bus   = in_bus;
        ds_allowin     = da;
        flush          = fl;
        @(negedge clk);
        check("allowin", 64'(fq_allowin), 64'(m_count != DEPTH));
        check("count", 64'(fq_count), 64'(m_count));
        byp = 1'b0;
`ifdef FQ_BYPASS_EN
        byp = (m_count == 0) && fv && !fl;
`endif
        exp_valid = ((m_count != 0) || byp) && !fl;
        check("valid", 64'(fq_to_ds_valid), 64'(exp_valid));
        if (exp_valid) begin
            check("head", 64'(fq_to_ds_bus), 64'(byp ? in_bus : exp_q[0]));
        end
        push   = fv && (m_count != DEPTH) && !fl;
        pop    = exp_valid && da;
        popped = pop;
        popped_pc = fq_to_ds_bus[BUS_WD-1 -: PC_WD];
        if (fl) begin
            exp_q.delete();
        end else begin
            if (push) exp_q.push_back(in_bus);
            if (pop) void'(exp_q.pop_front());
        end
        m_count = exp_q.size();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fs_to_fq_valid = 1'b0;
        fs_to_fq_bus   = '0;
        ds_allowin     = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && m_count != 0; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("drained", 64'(exp_q.size()), 64'd0);
        check("drain_count", 64'(fq_count), 64'd0);
    endtask

    initial begin
        logic [PC_WD-1:0] next_pc;
        n_checks = 0;
        n_fail   = 0;
        m_count  = 0;
        popped   = 1'b0;
        popped_pc = '0;
        idle_inputs();
        resetn = 1'b0;
        #12;
        check("rst_valid", 64'(fq_to_ds_valid), 64'd0);
        check("rst_allowin", 64'(fq_allowin), 64'd1);
        check("rst_count", 64'(fq_count), 64'd0);
        check("rst_bus", 64'(fq_to_ds_bus), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Fill then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'h1c00_0000 + 32'(4 * i), 1'b0, 1'b0);
        end
        check("full_allowin", 64'(fq_allowin), 64'd0);
        check("full_count", 64'(fq_count), 64'(DEPTH));
        step(1'b1, 32'h1c00_0ff0, 1'b0, 1'b0);
        next_pc = 32'h1c00_0000;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("fill_order", 64'(popped ? popped_pc : '1), 64'(next_pc));
            next_pc = next_pc + 32'd4;
        end
        check("empty_valid", 64'(fq_to_ds_valid), 64'd0);
        drain(8);

        // Wrap with occupancy held at 2
        step(1'b1, 32'h1c00_0010, 1'b0, 1'b0);
        step(1'b1, 32'h1c00_0014, 1'b0, 1'b0);
        next_pc = 32'h1c00_0010;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h1c00_0018 + 32'(4 * i), 1'b1, 1'b0);
            check("wrap_seq", 64'(popped ? popped_pc : '1), 64'(next_pc));
            check("wrap_count", 64'(fq_count), 64'd2);
            next_pc = next_pc + 32'd4;
        end
        drain(8);

        // Full with simultaneous pop: no push that cycle
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'h1c00_0040 + 32'(4 * i), 1'b0, 1'b0);
        end
        step(1'b1, 32'h1c00_0050, 1'b1, 1'b0);
        check("fullpop_count", 64'(fq_count), 64'd3);
        step(1'b1, 32'h1c00_0054, 1'b0, 1'b0);
        check("after_fullpop", 64'(fq_count), 64'(DEPTH));
        drain(8);

        // Flush drops contents and the concurrent push
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h1c00_0080 + 32'(4 * i), 1'b0, 1'b0);
        end
        step(1'b1, 32'h1c00_00ee, 1'b1, 1'b1);
        check("flush_count", 64'(fq_count), 64'd0);
        step(1'b1, 32'h1c00_0100, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("post_flush_pc", 64'(popped ? popped_pc : '1), 64'h1c00_0100);
        drain(8);

        // Asynchronous reset mid-run
        step(1'b1, 32'h1c00_0180, 1'b0, 1'b0);
        step(1'b1, 32'h1c00_0184, 1'b0, 1'b0);
        idle_inputs();
        #2;
        resetn = 1'b0;
        #1;
        check("arst_valid", 64'(fq_to_ds_valid), 64'd0);
        check("arst_count", 64'(fq_count), 64'd0);
        check("arst_allowin", 64'(fq_allowin), 64'd1);
        check("arst_bus", 64'(fq_to_ds_bus), 64'd0);
        exp_q.delete();
        m_count = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Empty-queue push with ID ready
        step(1'b1, 32'h1c00_0200, 1'b1, 1'b0);
`ifdef FQ_BYPASS_EN
        check("byp_count", 64'(fq_count), 64'd0);
`else
        check("nobyp_count", 64'(fq_count), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("nobyp_pc", 64'(popped ? popped_pc : '1), 64'h1c00_0200);
        check("nobyp_count0", 64'(fq_count), 64'd0);
`endif

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 32'h1c00_1000 + 32'(4 * i),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end
        drain(16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
